// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, default
// memory timeout and the MEM/WB bundle.
package pipe_pkg;

  localparam int TIMEOUT_DEF = 15;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        z;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } mem_wb_t;

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register; a bubble clears the write-back
// controls and holds every data field.
module pipemwreg
  import pipe_pkg::*;
(
  input  logic    clk,
  input  logic    clrn,
  input  logic    i_bubble,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);

  mem_wb_t r_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.wreg  <= 1'b0;
      r_q.m2reg <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: data-memory handshake FSM with access timeout,
// pipeline stall generation and the MEM/WB register.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic        mz,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  input  logic        dack,
  input  logic [31:0] drdata,
  output logic        mstall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic        wz,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        merr
);

  localparam int CW =
    ($clog2(TIMEOUT) < 4) ? 4 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dreq;
  logic          r_dwe;
  logic [31:0]   r_daddr;
  logic [31:0]   r_dwdata;
  logic          r_merr;

  logic    w_memop;
  logic    w_busy;
  logic    w_last;
  logic    w_done;
  logic    w_abort;
  mem_wb_t w_d;
  mem_wb_t w_q;

  assign w_memop = mm2reg | mwmem;
  assign w_busy  = (r_state == BUSY);
  assign w_last  = (r_cnt == LAST);
  // dack takes priority over the timeout in the same cycle
  assign w_done  = w_busy & dack;
  assign w_abort = w_busy & ~dack & w_last;

  always_comb begin
    mstall = 1'b0;
    if (w_busy) mstall = ~(dack | w_last);
    else        mstall = w_memop;
  end

  always_comb begin
    w_d       = '0;
    w_d.wreg  = mwreg & ~w_abort;
    w_d.m2reg = mm2reg;
    w_d.z     = mz;
    w_d.alu   = malu;
    w_d.rn    = mrn;
    w_d.mo    = (w_done & mm2reg) ? drdata : 32'h0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dreq   <= 1'b0;
      r_dwe    <= 1'b0;
      r_daddr  <= 32'h0;
      r_dwdata <= 32'h0;
      r_merr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memop) begin
            r_state  <= BUSY;
            r_daddr  <= malu;
            r_dwdata <= mb;
            r_dwe    <= mwmem;
            r_dreq   <= 1'b1;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          if (dack) begin
            r_state <= IDLE;
            r_dreq  <= 1'b0;
          end else if (w_last) begin
            r_state <= IDLE;
            r_dreq  <= 1'b0;
            r_merr  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dreq  <= 1'b0;
        end
      endcase
    end
  end

  pipemwreg u_mwreg (
    .clk      (clk),
    .clrn     (clrn),
    .i_bubble (mstall),
    .i_d      (w_d),
    .o_q      (w_q)
  );

  assign dreq   = r_dreq;
  assign dwe    = r_dwe;
  assign daddr  = r_daddr;
  assign dwdata = r_dwdata;
  assign merr   = r_merr;

  assign wwreg  = w_q.wreg;
  assign wm2reg = w_q.m2reg;
  assign wz     = w_q.z;
  assign wmo    = w_q.mo;
  assign walu   = w_q.alu;
  assign wrn    = w_q.rn;

endmodule
